// File: rtl/coffee_pkg.sv
// coffee_pkg: shared FSM states, drink codes and timing helpers for coffee_dispenser
package coffee_pkg;
  typedef enum logic [2:0] {IDLE, GRIND, WATER, MILK, DONE, WAIT_REL} state_t;
  typedef enum logic [1:0] {NONE, ESPRESSO, LONG, CAPPUCCINO} drink_t;
  function automatic int water_cycles(drink_t d, int base);
    return d == LONG ? 2 * base : d == NONE ? 0 : base;
  endfunction
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/coffee_dispenser_phase_timer.sv
// phase_timer: loadable down-counter shared by every actuator phase; expired marks the last counted cycle
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         hold,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!hold && cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == W'(1);
endmodule

// File: rtl/coffee_dispenser.sv
// coffee_dispenser: runs grind/water/milk for one latched drink request, pulses done, flags illegal requests
// Defining COFFEE_CUP_SENSE_EN adds cup_ok, which pauses an active sequence while the cup is missing
module coffee_dispenser
  import coffee_pkg::*;
#(
  parameter int GRIND_CYC = 4,
  parameter int WATER_CYC = 6,
  parameter int MILK_CYC  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic EF,
  input  logic EG,
  input  logic EH,
`ifdef COFFEE_CUP_SENSE_EN
  input  logic cup_ok,
`endif
  output logic grinder,
  output logic water,
  output logic milk,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int TW = $clog2(max3(GRIND_CYC, 2 * WATER_CYC, MILK_CYC) + 1);
  state_t        state, nxt;
  drink_t        drink, drink_nxt;
  logic          err_f, err_nxt, load, expired, cup;
  logic [TW-1:0] load_val;
  logic [1:0]    nreq;
`ifdef COFFEE_CUP_SENSE_EN
  assign cup = cup_ok;
`else
  assign cup = 1'b1;
`endif
  assign nreq = 2'(EF) + 2'(EG) + 2'(EH);
  phase_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .hold(!cup), .load_val(load_val), .expired(expired)
  );
  always_comb begin
    nxt = state;
    drink_nxt = drink;
    err_nxt = err_f;
    load = 1'b0;
    load_val = '0;
    case (state)
      IDLE:
        if (nreq == 2'd1 && cup) begin
          nxt = GRIND;
          drink_nxt = EF ? ESPRESSO : EG ? LONG : CAPPUCCINO;
          load = 1'b1;
          load_val = TW'(GRIND_CYC);
        end else if (nreq > 2'd1) begin
          nxt = WAIT_REL;
          err_nxt = 1'b1;
        end
      GRIND:
        if (expired && cup) begin
          nxt = WATER;
          load = 1'b1;
          load_val = TW'(water_cycles(drink, WATER_CYC));
        end
      WATER:
        if (expired && cup) begin
          nxt = drink == CAPPUCCINO ? MILK : DONE;
          load = drink == CAPPUCCINO;
          load_val = TW'(MILK_CYC);
        end
      MILK: nxt = expired && cup ? DONE : MILK;
      DONE: nxt = WAIT_REL;
      WAIT_REL:
        if (nreq == 2'd0) begin
          nxt = IDLE;
          err_nxt = 1'b0;
          drink_nxt = NONE;
        end
      default: nxt = IDLE;
    endcase
  end
  // outputs decode the registered state one edge later, so no input reaches a pin combinationally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      drink <= NONE;
      err_f <= 1'b0;
      {grinder, water, milk, busy, done, err} <= '0;
    end else begin
      state <= nxt;
      drink <= drink_nxt;
      err_f <= err_nxt;
      grinder <= state == GRIND && cup;
      water <= state == WATER && cup;
      milk <= state == MILK && cup;
      busy <= (state == GRIND || state == WATER || state == MILK) && cup;
      done <= state == DONE;
      err <= err_f;
    end
endmodule

// File: tb/tb_coffee_dispenser.sv
// tb_coffee_dispenser: directed and random requests checked against a schedule-queue model of the dispenser
module tb_coffee_dispenser;
  localparam int G = 4, W = 6, M = 3;
  localparam logic [3:0] PG = 4'b1000, PW = 4'b0100, PM = 4'b0010, PD = 4'b0001;
  logic clk = 1'b0, rst_n = 1'b0, ef = 1'b1, eg = 1'b0, eh = 1'b0, cup = 1'b1;
  logic grinder, water, milk, busy, done, err;
  logic [5:0] outs;
  int vectors = 0, miscompares = 0;
  logic [3:0] q[$];
  logic [3:0] cur = '0;
  bit waiting = 0, err_f = 0, err_o = 0;

  coffee_dispenser #(.GRIND_CYC(G), .WATER_CYC(W), .MILK_CYC(M)) dut (
    .clk(clk), .rst_n(rst_n), .EF(ef), .EG(eg), .EH(eh),
`ifdef COFFEE_CUP_SENSE_EN
    .cup_ok(cup),
`endif
    .grinder(grinder), .water(water), .milk(milk), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign outs = {grinder, water, milk, busy, done, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
    end
  endtask

  function automatic logic [5:0] expected();
    return {cur[3], cur[2], cur[1], |cur[3:1], cur[0], err_o};
  endfunction

  task automatic model_reset();
    q.delete();
    cur = '0;
    waiting = 0;
    err_f = 0;
    err_o = 0;
  endtask

  // a request expands into a list of per-cycle outputs; a missing cup only delays actuator entries
  task automatic model_step();
    int n, wc;
    n = int'(ef) + int'(eg) + int'(eh);
    err_o = err_f;
    if (q.size() != 0) begin
      if (q[0] != PD && !cup) cur = '0;
      else begin
        cur = q.pop_front();
        if (cur == PD) waiting = 1;
      end
    end else begin
      cur = '0;
      if (waiting) begin
        if (n == 0) begin
          waiting = 0;
          err_f = 0;
        end
      end else if (n == 1 && cup) begin
        wc = eg ? 2 * W : W;
        repeat (G) q.push_back(PG);
        repeat (wc) q.push_back(PW);
        if (eh) repeat (M) q.push_back(PM);
        q.push_back(PD);
      end else if (n > 1) begin
        err_f = 1;
        waiting = 1;
      end
    end
  endtask

  task automatic cycle(input string tag, input logic [2:0] req);
    {ef, eg, eh} = req;
    @(posedge clk);
    if (rst_n) model_step();
    #1 check(tag, 32'(outs), 32'(expected()));
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("reset_async", 32'(outs), 32'(expected()));
    @(posedge clk);
    #1 check("reset_hold", 32'(outs), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drink(input string tag, input logic [2:0] req, input int hold, input int pre, input int exp_lat);
    int lat = -1;
    repeat (pre) cycle("release", 3'b000);
    for (int i = 0; i < 24; i++) begin
      cycle(tag, i < hold ? req : 3'b000);
      check("onehot", 32'($countones({grinder, water, milk}) <= 1), 1);
      if (done && lat < 0) lat = i;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", 32'(outs), 0);
    rst_n = 1'b1;
    drink("espresso", 3'b100, 24, 0, 11);
    drink("long", 3'b010, 2, 2, 17);
    repeat (3) cycle("illegal", 3'b110);
    repeat (3) cycle("illegal_rel", 3'b000);
    drink("cappuccino", 3'b001, 24, 0, 14);
    repeat (2) cycle("release", 3'b000);
    repeat (8) cycle("long_rst", 3'b010);
    check("water_before_rst", 32'(water), 1);
    do_reset();
    drink("long_restart", 3'b010, 24, 0, 17);
`ifdef COFFEE_CUP_SENSE_EN
    repeat (2) cycle("release", 3'b000);
    for (int i = 0; i < 24; i++) begin
      cup = !(i >= 6 && i < 11);
      cycle("cup_pause", 3'b100);
      if (i == 16) check("cup_done_latency", 32'(done), 1);
    end
    cup = 1'b1;
`endif
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(9))
          0, 1, 2, 3, 4: {ef, eg, eh} = 3'b000;
          5, 6, 7: {ef, eg, eh} = 3'b001 << $urandom_range(2);
          default: {ef, eg, eh} = 3'b111 ^ (3'b001 << $urandom_range(3));
        endcase
      end
`ifdef COFFEE_CUP_SENSE_EN
      if ($urandom_range(5) == 0) cup = ~cup;
`endif
      if ($urandom_range(199) == 0) do_reset();
      cycle("random", {ef, eg, eh});
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/coffee_dispenser.md
# coffee_dispenser

Drink-execution controller on the consumer side of the selection FSM's end-state outputs (EF/EG/EH). It accepts exactly one held drink-state line, latches it, and runs a timed actuator sequence: grinder, water valve, optional milk valve. It reports completion with a one-cycle `done` pulse. Illegal requests are flagged, and a new drink is not started until the selection lines return low.

## Interface
- `GRIND_CYC`, default 4: grinder-on duration in clocks (≥1)
- `WATER_CYC`, default 6: base water duration in clocks (≥1)
- `MILK_CYC`, default 3: milk duration in clocks (≥1)
- `clk`  in  1: single clock, rising edge
- `rst_n`  in  1: asynchronous, active-low reset
- `EF`  in  1: request espresso (grind + WATER_CYC water)
- `EG`  in  1: request long coffee (grind + 2·WATER_CYC water)
- `EH`  in  1: request cappuccino (grind + WATER_CYC water + MILK_CYC milk)
- `cup_ok`  in  1: cup present (only with CUP_SENSE_EN)
- `grinder`  out  1: grinder motor enable
- `water`  out  1: water valve enable
- `milk`  out  1: milk valve enable
- `busy`  out  1: a sequence is in progress (GRIND..MILK)
- `done`  out  1: one-cycle pulse at sequence completion
- `err`  out  1: illegal request seen; sticky until the request lines all go low

## Operation
- States: IDLE, GRIND, WATER, MILK, DONE, WAIT_REL.
- **IDLE**
  - Exactly one of EF/EG/EH high: latch the drink and load the timer with GRIND_CYC; go to GRIND.
  - Two or more high: set `err`, go to WAIT_REL, no actuation.
  - All low: stay.
- **GRIND**
  - `grinder`=1.
  - On timer expiry, load the water time (WATER_CYC, or 2·WATER_CYC for EG); go to WATER.
- **WATER**
  - `water`=1.
  - On expiry: EH loads MILK_CYC and goes to MILK; the others go to DONE.
- **MILK**
  - `milk`=1.
  - On expiry go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle; go to WAIT_REL.
- **WAIT_REL**
  - Stay until EF=EG=EH=0, then clear `err` and go to IDLE.
- The latched drink is authoritative. Changes on EF/EG/EH after acceptance are ignored until WAIT_REL.
- At most one actuator output is high in any cycle.
- Timer width is `$clog2(max(GRIND_CYC, 2*WATER_CYC, MILK_CYC)+1)`. The doubling is computed at elaboration and must not overflow.

## Timing
- Reset values: all outputs 0; state IDLE; timer 0; latched drink cleared.
- All outputs are registered, with no combinational path from the inputs.
- A request sampled high at edge N asserts `grinder` from edge N+1.
- Each phase output is high for exactly its cycle count, and phases are back-to-back with no gap.
- `done` is high in the cycle after the last actuator cycle.
- Total request-to-done latency is 1 + GRIND + water + milk cycles.
- `busy`=1 exactly while `grinder|water|milk`.
- Reset asserted mid-sequence immediately drops every actuator (asynchronous). After release the block is in IDLE, and a still-held request starts a fresh sequence.
- A request held through DONE does not retrigger: WAIT_REL blocks it.
- `err` rises at the edge after the illegal sample. It falls at the edge after the release is sampled.

## Configuration
- `COFFEE_CUP_SENSE_EN` defined:
  - The `cup_ok` port exists.
  - In GRIND/WATER/MILK, `cup_ok`=0 freezes the timer and forces all actuators to 0; the state is held.
  - Resuming `cup_ok`=1 continues with the remaining count; no cycles are lost or added.
  - IDLE accepts a request only if `cup_ok`=1.
- Not defined: the port is absent, the cup is treated as always present, and there is no pause logic.

## Structure
- `coffee_pkg` holds the state enum, the drink enum (NONE/ESPRESSO/LONG/CAPPUCCINO), and a function returning water cycles per drink.
- Sub-module `phase_timer`:
  - Ports: load, load value, hold (pause), `expired` flag.
  - Single down-counter reused for every phase.

## Test plan
Defaults GRIND=4, WATER=6, MILK=3.
- **Espresso:** EF held high from reset release → `grinder` 4 cycles, `water` 6, `done` at request+11, no `milk`, no retrigger while EF held.
- **Long coffee:** EG pulse held 2 cycles → `water` 12 cycles, `done` at request+17; EG dropping mid-sequence has no effect.
- **Cappuccino:** EH high → grind 4, water 6, milk 3 back-to-back, `done` at request+14, one-hot actuators checked every cycle.
- **Illegal:** EF=EG=1 → `err`=1 next cycle, no actuators; both low → `err`=0 and back in IDLE; a subsequent EH runs normally.
- **Reset mid-water:** `rst_n` low in water cycle 3 → `water` drops the same instant; EG still high after release → a full new sequence.
- **CUP_SENSE_EN:** `cup_ok` low for 5 cycles in water cycle 2 of espresso → actuators off during the pause, total water still 6, `done` at request+16.
